if_stage: RTL and testbench

//  Instruction-fetch stage; sits directly upstream of id_stage and supplies its 32-bit inst.

---
 rtl/if_stage_pkg.sv | 15 +
 rtl/if_stage_if.sv | 35 +++
 rtl/if_stage_sync_fifo.sv | 49 ++++
 rtl/if_stage.sv | 107 ++++++++++
 tb/tb_if_stage.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package if_stage_pkg;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;  // addi x0,x0,0

    // One buffered fetch result: the instruction word and the PC it came from.
    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } inst_ent_t;

endpackage

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's memory, redirect and ID-facing handshakes.
// Latency: n/a (wires only).
// Backpressure: imem_req_ready stalls requests, id_ready stalls delivery to ID.
//
// Signals:
//   imem_req_valid/ready/addr  fetch request channel toward instruction memory
//   imem_resp_valid/data       in-order response words from memory
//   redirect_valid/pc          EXE branch/jump redirect
//   inst_valid/id_ready        handoff to id_stage, with inst and inst_pc
// Modports: master = fetch stage, slave = its environment.
interface if_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        id_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/if_stage_sync_fifo.sv
// Generic synchronous FIFO with flush and occupancy count.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: none internally; callers must not push when full (credit-limited).
//
// Ports: clk, rst (sync, active-high), i_flush (clears contents), i_push/i_push_dat,
//        i_pop (ignored when empty), o_head_dat (oldest entry), o_count (0..DEPTH).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_dat,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head_dat,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop;

    assign w_pop      = i_pop && (r_count != '0);
    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, w_pop};
        end
    end
endmodule

// File: rtl/if_stage.sv
// Instruction fetch: issues pipelined imem requests, buffers words with PCs, feeds ID.
// Latency: response word visible to ID one cycle after imem_resp_valid.
// Backpressure: at most DEPTH requests in flight plus buffered words; id_ready=0 stalls fetch.
//
// Ports: clk, rst (sync, active-high), bus (if_stage_if.master: imem request/response,
//        EXE redirect, inst/inst_pc handoff to id_stage).
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic       clk,
    input  logic       rst,
    if_stage_if.master bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [63:0]      r_fetch_pc;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [CNT_W-1:0] w_out_cnt;
    logic [CNT_W-1:0] w_buf_cnt;
    logic [63:0]      w_pcq_head;
    inst_ent_t        w_buf_head;
    inst_ent_t        w_buf_in;
    logic             w_credit_ok;
    logic             w_req_fire;
    logic             w_resp_fire;
    logic             w_drop;
    logic             w_buf_push;
    logic             w_buf_pop;
    logic             w_inst_vld;

    // Every in-flight request and every buffered word holds one of DEPTH slots,
    // so a response always has room in the buffer.
    assign w_credit_ok = ({1'b0, w_out_cnt} + {1'b0, w_buf_cnt}) < (CNT_W+1)'(DEPTH);

    assign bus.imem_req_valid = !rst && !bus.redirect_valid && w_credit_ok;
    assign bus.imem_req_addr  = r_fetch_pc;

    assign w_req_fire  = bus.imem_req_valid && bus.imem_req_ready;
    assign w_resp_fire = bus.imem_resp_valid;

    // Wrong-path words: anything still owed from before a redirect, plus a
    // word arriving in the redirect cycle itself.
    assign w_drop     = bus.redirect_valid || (r_drop_cnt != '0);
    assign w_buf_push = w_resp_fire && !w_drop;
    assign w_buf_in   = '{inst: bus.imem_resp_data, pc: w_pcq_head};

    assign w_inst_vld = (w_buf_cnt != '0);
    assign w_buf_pop  = w_inst_vld && bus.id_ready;

    assign bus.inst_valid = w_inst_vld;
    assign bus.inst       = w_inst_vld ? w_buf_head.inst : INST_NOP;
    assign bus.inst_pc    = w_inst_vld ? w_buf_head.pc   : 64'd0;

    // PC queue occupancy is exactly the outstanding-request count. It is never
    // flushed by a redirect: dropped responses still pop their own PC.
    sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_pc_q (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (1'b0),
        .i_push     (w_req_fire),
        .i_push_dat (r_fetch_pc),
        .i_pop      (w_resp_fire),
        .o_head_dat (w_pcq_head),
        .o_count    (w_out_cnt)
    );

    sync_fifo #(.WIDTH($bits(inst_ent_t)), .DEPTH(DEPTH)) u_inst_buf (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (bus.redirect_valid),
        .i_push     (w_buf_push),
        .i_push_dat (w_buf_in),
        .i_pop      (w_buf_pop),
        .o_head_dat (w_buf_head),
        .o_count    (w_buf_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (bus.redirect_valid) begin
            r_fetch_pc <= bus.redirect_pc & ~64'h3;
        end else if (w_req_fire) begin
            r_fetch_pc <= r_fetch_pc + 64'd4;
        end
    end

    // On redirect every request still in flight after this cycle becomes a drop;
    // a response landing in the same cycle is already discarded via w_drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else begin
            if (bus.redirect_valid) begin
                r_drop_cnt <= w_out_cnt - CNT_W'(w_resp_fire);
            end else if (w_resp_fire && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - 1'b1;
            end
            if (w_resp_fire) begin
                assert (w_out_cnt != '0);
            end
        end
    end
endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    import if_stage_pkg::*;

    localparam int          DEPTH  = 2;
    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic clk = 1'b0;
    logic rst;

    if_stage_if bus();

    if_stage #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct { logic [63:0] pc; int due; } pend_t;
    pend_t pend_q[$];
    int    cyc     = 0;
    int    lat_min = 1;
    int    lat_max = 1;

    // Memory contents as a pure function of address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
    endfunction

    // Instruction memory: in-order responses, latency >= 1, shares rst.
    initial begin
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = '0;
            if (!rst && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = mem_word(pend_q[0].pc);
                void'(pend_q.pop_front());
            end
        end
    end

    // Reference model: requests and ID deliveries must each form the sequential
    // correct-path PC stream, restarting at RESET_PC on reset and at the aligned
    // target on redirect; delivered words must be the memory word at that PC.
    logic [63:0] exp_req_pc = RST_PC;
    logic [63:0] exp_id_pc  = RST_PC;
    int          n_out      = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_addr  = '0;

    always @(negedge clk) begin
        int lat;
        if (rst) begin
            pend_q.delete();
            n_out      = 0;
            exp_req_pc = RST_PC;
            exp_id_pc  = RST_PC;
            prev_stall = 1'b0;
            n_vec++;
            if (bus.imem_req_valid !== 1'b0) begin
                n_err++;
                $display("FAIL sb_rst_req_valid: got %b expected 0", bus.imem_req_valid);
            end
        end else begin
            if (bus.imem_resp_valid) n_out--;
            if (bus.redirect_valid) begin
                n_vec++;
                if (bus.imem_req_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL sb_redirect_req_valid: got %b expected 0", bus.imem_req_valid);
                end
                exp_req_pc = bus.redirect_pc & ~64'h3;
                exp_id_pc  = bus.redirect_pc & ~64'h3;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    n_vec++;
                    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== prev_addr) begin
                        n_err++;
                        $display("FAIL sb_req_hold: got valid=%b addr=%h expected valid=1 addr=%h",
                                 bus.imem_req_valid, bus.imem_req_addr, prev_addr);
                    end
                end
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    n_vec++;
                    if (bus.imem_req_addr !== exp_req_pc) begin
                        n_err++;
                        $display("FAIL sb_req_addr: got %h expected %h", bus.imem_req_addr, exp_req_pc);
                    end
                    lat = int'($urandom_range(lat_max, lat_min));
                    pend_q.push_back('{bus.imem_req_addr, cyc + lat});
                    n_out++;
                    exp_req_pc = exp_req_pc + 64'd4;
                    n_vec++;
                    if (n_out > DEPTH) begin
                        n_err++;
                        $display("FAIL sb_credit: got %0d outstanding expected <= %0d", n_out, DEPTH);
                    end
                end
                if (bus.inst_valid) begin
                    if (bus.id_ready) begin
                        n_vec++;
                        if (bus.inst_pc !== exp_id_pc || bus.inst !== mem_word(exp_id_pc)) begin
                            n_err++;
                            $display("FAIL sb_id_stream: got pc=%h inst=%h expected pc=%h inst=%h",
                                     bus.inst_pc, bus.inst, exp_id_pc, mem_word(exp_id_pc));
                        end
                        exp_id_pc = exp_id_pc + 64'd4;
                    end
                end else begin
                    n_vec++;
                    if (bus.inst !== INST_NOP || bus.inst_pc !== 64'd0) begin
                        n_err++;
                        $display("FAIL sb_idle_nop: got inst=%h pc=%h expected %h/0",
                                 bus.inst, bus.inst_pc, INST_NOP);
                    end
                end
                prev_stall = bus.imem_req_valid && !bus.imem_req_ready;
                prev_addr  = bus.imem_req_addr;
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        repeat (n) next();
        rst = 1'b0;
    endtask

    // 1: reset values, then first request at RESET_PC.
    task automatic test_reset();
        bus.imem_req_ready = 1'b0;
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.imem_req_valid !== 1'b0) begin
                n_err++;
                $display("FAIL reset_req_valid: got %b expected 0", bus.imem_req_valid);
            end
            if (i > 0) begin
                n_vec++;
                if (bus.inst_valid !== 1'b0 || bus.inst !== INST_NOP || bus.inst_pc !== 64'd0) begin
                    n_err++;
                    $display("FAIL reset_outputs: got v=%b inst=%h pc=%h expected 0/%h/0",
                             bus.inst_valid, bus.inst, bus.inst_pc, INST_NOP);
                end
            end
            next();
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RST_PC) begin
            n_err++;
            $display("FAIL reset_first_req: got v=%b addr=%h expected 1/%h",
                     bus.imem_req_valid, bus.imem_req_addr, RST_PC);
        end
        next();
    endtask

    // 6a: memory not ready for 5 cycles; address holds, PC does not advance.
    task automatic test_req_stall();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RST_PC) begin
                n_err++;
                $display("FAIL stall_hold: got v=%b addr=%h expected 1/%h",
                         bus.imem_req_valid, bus.imem_req_addr, RST_PC);
            end
            next();
        end
        bus.imem_req_ready = 1'b1;
        next();
        @(negedge clk);
        n_vec++;
        if (bus.imem_req_addr !== RST_PC + 64'd4) begin
            n_err++;
            $display("FAIL stall_advance: got %h expected %h", bus.imem_req_addr, RST_PC + 64'd4);
        end
        next();
    endtask

    // 2: streaming with latency 1, ID always ready.
    task automatic test_stream();
        logic [63:0] got[$];
        lat_min = 1; lat_max = 1;
        bus.imem_req_ready = 1'b1;
        bus.id_ready       = 1'b1;
        do_reset(2);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.inst_valid && bus.id_ready) got.push_back(bus.inst_pc);
            next();
        end
        n_vec++;
        if (got.size() < 6) begin
            n_err++;
            $display("FAIL stream_count: got %0d insts expected >= 6", got.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_vec++;
                if (got[i] !== RST_PC + 64'(4 * i)) begin
                    n_err++;
                    $display("FAIL stream_pc%0d: got %h expected %h", i, got[i], RST_PC + 64'(4 * i));
                end
            end
        end
    endtask

    // 3: ID backpressure fills the credits, head stays stable, then resumes.
    task automatic test_backpressure();
        int fires = 0;
        bit resumed = 0;
        lat_min = 1; lat_max = 1;
        bus.imem_req_ready = 1'b1;
        bus.id_ready       = 1'b0;
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.imem_req_valid && bus.imem_req_ready) fires++;
            next();
        end
        n_vec++;
        if (fires != DEPTH) begin
            n_err++;
            $display("FAIL bp_fires: got %0d expected %0d", fires, DEPTH);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b1 ||
                bus.inst_pc !== RST_PC || bus.inst !== mem_word(RST_PC)) begin
                n_err++;
                $display("FAIL bp_stable: got rv=%b iv=%b pc=%h inst=%h expected 0/1/%h/%h",
                         bus.imem_req_valid, bus.inst_valid, bus.inst_pc, bus.inst,
                         RST_PC, mem_word(RST_PC));
            end
            next();
        end
        bus.id_ready = 1'b1;
        for (int i = 0; i < 6 && !resumed; i++) begin
            @(negedge clk);
            if (bus.imem_req_valid && bus.imem_req_ready) resumed = 1;
            next();
        end
        n_vec++;
        if (!resumed) begin
            n_err++;
            $display("FAIL bp_resume: got no request within 6 cycles expected one");
        end
    endtask

    // Watch for the first request and first ID delivery after a redirect.
    task automatic watch_after_redirect(input string name, input logic [63:0] tgt);
        logic [63:0] first_req = '1;
        logic [63:0] first_id  = '1;
        bit got_req = 0, got_id = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!got_req && bus.imem_req_valid && bus.imem_req_ready) begin
                got_req = 1; first_req = bus.imem_req_addr;
            end
            if (!got_id && bus.inst_valid && bus.id_ready) begin
                got_id = 1; first_id = bus.inst_pc;
            end
            next();
        end
        n_vec++;
        if (!got_req || first_req !== tgt) begin
            n_err++;
            $display("FAIL %s_first_req: got %h (seen=%0d) expected %h", name, first_req, got_req, tgt);
        end
        n_vec++;
        if (!got_id || first_id !== tgt) begin
            n_err++;
            $display("FAIL %s_first_inst: got %h (seen=%0d) expected %h", name, first_id, got_id, tgt);
        end
    endtask

    // 4: redirect with two requests outstanding; both are dropped.
    task automatic test_redirect();
        lat_min = 3; lat_max = 3;
        bus.imem_req_ready = 1'b1;
        bus.id_ready       = 1'b1;
        do_reset(2);
        next();
        next();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h0000_0000_8000_1002;
        next();
        bus.redirect_valid = 1'b0;
        watch_after_redirect("redir", 64'h0000_0000_8000_1000);
    endtask

    // 5: redirect in the same cycle as a response; that word is discarded.
    task automatic test_redirect_resp();
        logic [63:0] tgt;
        lat_min = 1; lat_max = 1;
        bus.imem_req_ready = 1'b1;
        bus.id_ready       = 1'b1;
        do_reset(2);
        next();
        tgt = {$urandom, $urandom};
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = tgt;
        next();
        bus.redirect_valid = 1'b0;
        watch_after_redirect("redir_resp", tgt & ~64'h3);
    endtask

    // 6b: reset in the middle of random traffic.
    task automatic test_reset_mid();
        lat_min = 1; lat_max = 3;
        do_reset(2);
        for (int i = 0; i < 30; i++) begin
            bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            bus.id_ready       = ($urandom_range(0, 1) != 0);
            next();
        end
        bus.imem_req_ready = 1'b1;
        bus.id_ready       = 1'b1;
        rst = 1'b1;
        next();
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.inst_valid !== 1'b0 || bus.inst !== INST_NOP || bus.inst_pc !== 64'd0 ||
            bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RST_PC) begin
            n_err++;
            $display("FAIL reset_mid: got iv=%b inst=%h pc=%h rv=%b addr=%h expected 0/%h/0/1/%h",
                     bus.inst_valid, bus.inst, bus.inst_pc, bus.imem_req_valid,
                     bus.imem_req_addr, INST_NOP, RST_PC);
        end
        next();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 10; i++) next();
    endtask

    // Long random run: random ready/latency/redirects/resets; model checks stream.
    task automatic test_random();
        int accepted = 0;
        lat_min = 1; lat_max = 4;
        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            bus.id_ready       = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = ($urandom_range(0, 24) == 0);
            bus.redirect_pc    = {$urandom, $urandom};
            rst                = ($urandom_range(0, 599) == 0);
            @(negedge clk);
            if (!rst && !bus.redirect_valid && bus.inst_valid && bus.id_ready) accepted++;
            next();
        end
        rst = 1'b0;
        bus.redirect_valid = 1'b0;
        n_vec++;
        if (accepted < 200) begin
            n_err++;
            $display("FAIL random_progress: got %0d insts expected >= 200", accepted);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        test_reset();
        test_req_stall();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_resp();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
